// File: rtl/ib_refresh_pkg.sv
// Shared types and constants for the IB-RAM iteration refresh sequencer.
package ib_refresh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_DRAIN = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_DONE       = 3'd4
    } refresh_state_e;

    localparam int unsigned ITER_NUM_DEF = 16;

    localparam int unsigned WE_F0 = 0;
    localparam int unsigned WE_F1 = 1;
    localparam int unsigned WE_DN = 2;

    function automatic int unsigned iter_bw(input int unsigned iter_num);
        return (iter_num > 1) ? $clog2(iter_num) : 1;
    endfunction

    // Each iteration table occupies 2*PAGE_CNT ROM words: A half then B half.
    function automatic int unsigned rom_base(input int unsigned iter, input int unsigned page_cnt);
        return iter * 2 * page_cnt;
    endfunction

endpackage

// File: rtl/ib_refresh_align_pipe.sv
// Delay line aligning page index/valid with the IB-ROM read latency; clr_i empties it.
module ib_refresh_align_pipe #(
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned PAGE_BW = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               vld_i,
    input  logic [PAGE_BW-1:0] page_i,
    output logic               vld_o,
    output logic [PAGE_BW-1:0] page_o
);

    logic [DEPTH-1:0]   vld_q;
    logic [PAGE_BW-1:0] page_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) page_q[i] <= '0;
        end else begin
            if (clr_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= vld_i;
                for (int unsigned i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
            end
            page_q[0] <= page_i;
            for (int unsigned i = 1; i < DEPTH; i++) page_q[i] <= page_q[i-1];
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign page_o = page_q[DEPTH-1];

endmodule

// File: rtl/ib_ram_refresh_ctrl.sv
// Streams one iteration's IB tables from the VN/DN IB-ROMs into the IB-RAMs.
// Optional IB_REFRESH_RANGE_CHK_EN adds iteration range checking and the err port.
module ib_ram_refresh_ctrl
    import ib_refresh_pkg::*;
#(
    parameter int unsigned VN_ROM_RD_BW    = 8,
    parameter int unsigned VN_ROM_ADDR_BW  = 11,
    parameter int unsigned VN_PAGE_ADDR_BW = 6,
    parameter int unsigned DN_ROM_RD_BW    = 2,
    parameter int unsigned DN_ROM_ADDR_BW  = 11,
    parameter int unsigned DN_PAGE_ADDR_BW = 6,
    parameter int unsigned PAGE_CNT        = 64,
    parameter int unsigned ITER_NUM        = ITER_NUM_DEF,
    parameter int unsigned ROM_RD_LATENCY  = 1,
    localparam int unsigned ITER_BW        = iter_bw(ITER_NUM)
) (
    input  logic                       write_clk,
    input  logic                       rstn,
    input  logic                       refresh_req,
    input  logic [ITER_BW-1:0]         refresh_iter,
    input  logic                       refresh_abort,
    input  logic                       pipe_drained,
    output logic                       busy,
    output logic                       done,
    output logic [VN_ROM_ADDR_BW-1:0]  rom_addrA_vn,
    output logic [VN_ROM_ADDR_BW-1:0]  rom_addrB_vn,
    output logic [DN_ROM_ADDR_BW-1:0]  rom_addrA_dn,
    output logic [DN_ROM_ADDR_BW-1:0]  rom_addrB_dn,
    input  logic [VN_ROM_RD_BW-1:0]    rom_dataA_0,
    input  logic [VN_ROM_RD_BW-1:0]    rom_dataB_0,
    input  logic [VN_ROM_RD_BW-1:0]    rom_dataA_1,
    input  logic [VN_ROM_RD_BW-1:0]    rom_dataB_1,
    input  logic [DN_ROM_RD_BW-1:0]    rom_dataA_2,
    input  logic [DN_ROM_RD_BW-1:0]    rom_dataB_2,
    output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_0,
    output logic [VN_PAGE_ADDR_BW:0]   page_addr_ram_1,
    output logic [DN_PAGE_ADDR_BW:0]   page_addr_ram_2,
    output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_0,
    output logic [VN_ROM_RD_BW-1:0]    ram_write_dataB_0,
    output logic [VN_ROM_RD_BW-1:0]    ram_write_dataA_1,
    output logic [VN_ROM_RD_BW-1:0]    ram_write_dataB_1,
    output logic [DN_ROM_RD_BW-1:0]    ram_write_dataA_2,
    output logic [DN_ROM_RD_BW-1:0]    ram_write_dataB_2,
    output logic [2:0]                 ib_ram_we
`ifdef IB_REFRESH_RANGE_CHK_EN
    ,
    output logic                       err
`endif
);

    localparam int unsigned CNT_BW = $clog2(PAGE_CNT);
    localparam int unsigned VN_PW  = VN_PAGE_ADDR_BW + 1;
    localparam int unsigned DN_PW  = DN_PAGE_ADDR_BW + 1;
    localparam logic [CNT_BW-1:0] LAST_PAGE  = CNT_BW'(PAGE_CNT - 1);
    localparam logic [1:0]        FLUSH_LAST = 2'(ROM_RD_LATENCY - 1);

    refresh_state_e            state_q;
    logic [ITER_BW-1:0]        iter_q;
    logic [CNT_BW-1:0]         page_q;
    logic [1:0]                flush_q;
    logic                      busy_q, done_q;
    logic [VN_ROM_ADDR_BW-1:0] addrA_vn_q, addrB_vn_q;
    logic [DN_ROM_ADDR_BW-1:0] addrA_dn_q, addrB_dn_q;

    logic                      abort_act, issue_vld, iter_ok;
    int unsigned               addr_d;

    assign abort_act = refresh_abort && (state_q != ST_IDLE);
    assign issue_vld = (state_q == ST_ISSUE);

    always_comb begin
        addr_d = rom_base(32'(iter_q), PAGE_CNT);
        if (state_q == ST_ISSUE) addr_d = addr_d + 32'(page_q) + 32'd1;
    end

`ifdef IB_REFRESH_RANGE_CHK_EN
    logic err_q;
    assign iter_ok = (32'(refresh_iter) < ITER_NUM);
    assign err     = err_q;
`else
    assign iter_ok = 1'b1;
`endif

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            iter_q     <= '0;
            page_q     <= '0;
            flush_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addrA_vn_q <= '0;
            addrB_vn_q <= '0;
            addrA_dn_q <= '0;
            addrB_dn_q <= '0;
`ifdef IB_REFRESH_RANGE_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef IB_REFRESH_RANGE_CHK_EN
            err_q  <= 1'b0;
`endif
            if (abort_act) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (refresh_req && !refresh_abort) begin
                            if (iter_ok) begin
                                iter_q  <= refresh_iter;
                                busy_q  <= 1'b1;
                                state_q <= ST_WAIT_DRAIN;
                            end
`ifdef IB_REFRESH_RANGE_CHK_EN
                            else err_q <= 1'b1;
`endif
                        end
                    end
                    ST_WAIT_DRAIN: begin
                        if (pipe_drained) begin
                            page_q     <= '0;
                            addrA_vn_q <= VN_ROM_ADDR_BW'(addr_d);
                            addrB_vn_q <= VN_ROM_ADDR_BW'(addr_d + PAGE_CNT);
                            addrA_dn_q <= DN_ROM_ADDR_BW'(addr_d);
                            addrB_dn_q <= DN_ROM_ADDR_BW'(addr_d + PAGE_CNT);
                            state_q    <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (page_q == LAST_PAGE) begin
                            flush_q <= '0;
                            state_q <= ST_FLUSH;
                        end else begin
                            page_q     <= page_q + 1'b1;
                            addrA_vn_q <= VN_ROM_ADDR_BW'(addr_d);
                            addrB_vn_q <= VN_ROM_ADDR_BW'(addr_d + PAGE_CNT);
                            addrA_dn_q <= DN_ROM_ADDR_BW'(addr_d);
                            addrB_dn_q <= DN_ROM_ADDR_BW'(addr_d + PAGE_CNT);
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_q == FLUSH_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            flush_q <= flush_q + 1'b1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    logic              wr_vld;
    logic [CNT_BW-1:0] wr_page;

    ib_refresh_align_pipe #(
        .DEPTH   (ROM_RD_LATENCY),
        .PAGE_BW (CNT_BW)
    ) u_align (
        .clk_i  (write_clk),
        .rst_ni (rstn),
        .clr_i  (abort_act),
        .vld_i  (issue_vld),
        .page_i (page_q),
        .vld_o  (wr_vld),
        .page_o (wr_page)
    );

    // Outputs follow the ROM directly on write cycles and hold the last written values otherwise.
    logic [CNT_BW-1:0]       page_hold_q;
    logic [VN_ROM_RD_BW-1:0] dA0_q, dB0_q, dA1_q, dB1_q;
    logic [DN_ROM_RD_BW-1:0] dA2_q, dB2_q;
    logic [CNT_BW-1:0]       page_cur;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            page_hold_q <= '0;
            dA0_q <= '0; dB0_q <= '0; dA1_q <= '0; dB1_q <= '0;
            dA2_q <= '0; dB2_q <= '0;
        end else if (wr_vld) begin
            page_hold_q <= wr_page;
            dA0_q <= rom_dataA_0; dB0_q <= rom_dataB_0;
            dA1_q <= rom_dataA_1; dB1_q <= rom_dataB_1;
            dA2_q <= rom_dataA_2; dB2_q <= rom_dataB_2;
        end
    end

    always_comb begin
        page_cur          = wr_vld ? wr_page     : page_hold_q;
        ram_write_dataA_0 = wr_vld ? rom_dataA_0 : dA0_q;
        ram_write_dataB_0 = wr_vld ? rom_dataB_0 : dB0_q;
        ram_write_dataA_1 = wr_vld ? rom_dataA_1 : dA1_q;
        ram_write_dataB_1 = wr_vld ? rom_dataB_1 : dB1_q;
        ram_write_dataA_2 = wr_vld ? rom_dataA_2 : dA2_q;
        ram_write_dataB_2 = wr_vld ? rom_dataB_2 : dB2_q;
        ib_ram_we         = '0;
        ib_ram_we[WE_F0]  = wr_vld;
        ib_ram_we[WE_F1]  = wr_vld;
        ib_ram_we[WE_DN]  = wr_vld;
    end

    assign page_addr_ram_0 = VN_PW'(page_cur);
    assign page_addr_ram_1 = VN_PW'(page_cur);
    assign page_addr_ram_2 = DN_PW'(page_cur);

    assign busy         = busy_q;
    assign done         = done_q;
    assign rom_addrA_vn = addrA_vn_q;
    assign rom_addrB_vn = addrB_vn_q;
    assign rom_addrA_dn = addrA_dn_q;
    assign rom_addrB_dn = addrB_dn_q;

endmodule

// File: tb/tb_ib_ram_refresh_ctrl.sv
// Directed bench for ib_ram_refresh_ctrl with a timeline model and per-cycle compare.
module tb_ib_ram_refresh_ctrl;

    localparam int L = 1;
`ifdef IB_REFRESH_RANGE_CHK_EN
    localparam int ITER_N = 12;
`else
    localparam int ITER_N = 16;
`endif
    localparam int PC = 64;

    logic        write_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        refresh_req = 1'b0;
    logic [3:0]  refresh_iter = '0;
    logic        refresh_abort = 1'b0;
    logic        pipe_drained = 1'b1;
    logic        busy, done;
    logic [10:0] rom_addrA_vn, rom_addrB_vn, rom_addrA_dn, rom_addrB_dn;
    logic [7:0]  rom_dataA_0, rom_dataB_0, rom_dataA_1, rom_dataB_1;
    logic [1:0]  rom_dataA_2, rom_dataB_2;
    logic [6:0]  page_addr_ram_0, page_addr_ram_1, page_addr_ram_2;
    logic [7:0]  ram_write_dataA_0, ram_write_dataB_0, ram_write_dataA_1, ram_write_dataB_1;
    logic [1:0]  ram_write_dataA_2, ram_write_dataB_2;
    logic [2:0]  ib_ram_we;
`ifdef IB_REFRESH_RANGE_CHK_EN
    logic        err;
`endif

    always #5 write_clk = ~write_clk;

    ib_ram_refresh_ctrl #(
        .ITER_NUM       (ITER_N),
        .ROM_RD_LATENCY (L)
    ) dut (
        .write_clk         (write_clk),
        .rstn              (rstn),
        .refresh_req       (refresh_req),
        .refresh_iter      (refresh_iter),
        .refresh_abort     (refresh_abort),
        .pipe_drained      (pipe_drained),
        .busy              (busy),
        .done              (done),
        .rom_addrA_vn      (rom_addrA_vn),
        .rom_addrB_vn      (rom_addrB_vn),
        .rom_addrA_dn      (rom_addrA_dn),
        .rom_addrB_dn      (rom_addrB_dn),
        .rom_dataA_0       (rom_dataA_0),
        .rom_dataB_0       (rom_dataB_0),
        .rom_dataA_1       (rom_dataA_1),
        .rom_dataB_1       (rom_dataB_1),
        .rom_dataA_2       (rom_dataA_2),
        .rom_dataB_2       (rom_dataB_2),
        .page_addr_ram_0   (page_addr_ram_0),
        .page_addr_ram_1   (page_addr_ram_1),
        .page_addr_ram_2   (page_addr_ram_2),
        .ram_write_dataA_0 (ram_write_dataA_0),
        .ram_write_dataB_0 (ram_write_dataB_0),
        .ram_write_dataA_1 (ram_write_dataA_1),
        .ram_write_dataB_1 (ram_write_dataB_1),
        .ram_write_dataA_2 (ram_write_dataA_2),
        .ram_write_dataB_2 (ram_write_dataB_2),
        .ib_ram_we         (ib_ram_we)
`ifdef IB_REFRESH_RANGE_CHK_EN
        ,
        .err               (err)
`endif
    );

    function automatic logic [7:0] f0(input logic [10:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] f1(input logic [10:0] a);
        return a[10:3] + 8'h11;
    endfunction
    function automatic logic [1:0] fdn(input logic [10:0] a);
        return a[1:0] ^ a[5:4];
    endfunction

    // Synchronous IB-ROMs with L cycles of read latency.
    logic [10:0] pa_vn [L], pb_vn [L], pa_dn [L], pb_dn [L];
    always @(posedge write_clk) begin
        pa_vn[0] <= rom_addrA_vn; pb_vn[0] <= rom_addrB_vn;
        pa_dn[0] <= rom_addrA_dn; pb_dn[0] <= rom_addrB_dn;
        for (int i = 1; i < L; i++) begin
            pa_vn[i] <= pa_vn[i-1]; pb_vn[i] <= pb_vn[i-1];
            pa_dn[i] <= pa_dn[i-1]; pb_dn[i] <= pb_dn[i-1];
        end
    end
    assign rom_dataA_0 = f0(pa_vn[L-1]);
    assign rom_dataB_0 = f0(pb_vn[L-1]);
    assign rom_dataA_1 = f1(pa_vn[L-1]);
    assign rom_dataB_1 = f1(pb_vn[L-1]);
    assign rom_dataA_2 = fdn(pa_dn[L-1]);
    assign rom_dataB_2 = fdn(pb_dn[L-1]);

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a refresh accepted at edge acc, drained at edge ed issues
    // pages during the ed..ed+PC-1 periods, writes page k L periods later, and
    // finishes with done in period ed+PC+L. An abort at edge ab_e cuts everything from there.
    int          cyc, acc_e, ed, ab_e, riter;
    bit          act;
    bit          e_busy, e_done, e_err;
    logic [2:0]  e_we;
    logic [10:0] e_aA, e_aB;
    logic [6:0]  e_page;
    logic [7:0]  e_dA0, e_dB0, e_dA1, e_dB1;
    logic [1:0]  e_dA2, e_dB2;

    always @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            cyc = 0; act = 0; acc_e = 0; ed = -1; ab_e = -1; riter = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_we = '0;
            e_aA = '0; e_aB = '0; e_page = '0;
            e_dA0 = '0; e_dB0 = '0; e_dA1 = '0; e_dB1 = '0; e_dA2 = '0; e_dB2 = '0;
        end else begin
            int n, k, j, base;
            logic [10:0] wa, wb;
            bit live;
            cyc++;
            n = cyc;
            e_err = 0;
            if (act && ed >= 0 && n >= ed + PC + L + 2) act = 0;
            if (!act) begin
                if (refresh_req && !refresh_abort) begin
`ifdef IB_REFRESH_RANGE_CHK_EN
                    if (int'(refresh_iter) >= ITER_N) e_err = 1;
                    else begin act = 1; acc_e = n; ed = -1; ab_e = -1; riter = int'(refresh_iter); end
`else
                    act = 1; acc_e = n; ed = -1; ab_e = -1; riter = int'(refresh_iter);
`endif
                end
            end else if (refresh_abort) begin
                act = 0; ab_e = n;
            end else if (ed < 0 && pipe_drained) begin
                ed = n;
            end
            base   = riter * 2 * PC;
            live   = (ab_e < 0) || (n < ab_e);
            e_busy = act && (ed < 0 || n <= ed + PC - 1 + L);
            e_done = act && ed >= 0 && n == ed + PC + L;
            j = n - ed;
            if (ed >= 0 && live && j >= 0 && j < PC) begin
                e_aA = 11'(base + j);
                e_aB = 11'(base + j + PC);
            end
            k = n - ed - L;
            if (ed >= 0 && live && k >= 0 && k < PC) begin
                wa = 11'(base + k);
                wb = 11'(base + k + PC);
                e_we = 3'b111; e_page = 7'(k);
                e_dA0 = f0(wa); e_dB0 = f0(wb);
                e_dA1 = f1(wa); e_dB1 = f1(wb);
                e_dA2 = fdn(wa); e_dB2 = fdn(wb);
            end else begin
                e_we = 3'b000;
            end
        end
    end

    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;

    always @(negedge write_clk) begin
        if (ib_ram_we == 3'b111) wr_cnt++;
        if (done) done_cnt++;
`ifdef IB_REFRESH_RANGE_CHK_EN
        if (err) err_cnt++;
`endif
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("we", ib_ram_we, e_we);
        chk("addrA_vn", rom_addrA_vn, e_aA);
        chk("addrB_vn", rom_addrB_vn, e_aB);
        chk("addrA_dn", rom_addrA_dn, e_aA);
        chk("addrB_dn", rom_addrB_dn, e_aB);
        chk("page0", page_addr_ram_0, e_page);
        chk("page1", page_addr_ram_1, e_page);
        chk("page2", page_addr_ram_2, e_page);
        chk("dA0", ram_write_dataA_0, e_dA0);
        chk("dB0", ram_write_dataB_0, e_dB0);
        chk("dA1", ram_write_dataA_1, e_dA1);
        chk("dB1", ram_write_dataB_1, e_dB1);
        chk("dA2", ram_write_dataA_2, e_dA2);
        chk("dB2", ram_write_dataB_2, e_dB2);
`ifdef IB_REFRESH_RANGE_CHK_EN
        chk("err", err, e_err);
`endif
    end

    task automatic tick();
        @(posedge write_clk);
        #2;
    endtask

    task automatic do_req(input logic [3:0] it);
        refresh_req  = 1'b1;
        refresh_iter = it;
        tick();
        refresh_req  = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_addr(input int a, input int limit);
        int n;
        n = 0;
        while (rom_addrA_vn !== 11'(a) && n < limit) begin
            tick();
            n++;
        end
        chk("addr_reach", rom_addrA_vn, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wb, db, eb;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_we", ib_ram_we, 0);
        chk("rst_addr", rom_addrA_vn, 0);
        rstn = 1'b1;
        tick();

        // Nominal refresh of iteration 3.
        wb = wr_cnt; db = done_cnt;
        do_req(4'd3);
        chk("t1_busy_c1", busy, 1);
        tick();
        chk("t1_addrA", rom_addrA_vn, 384);
        chk("t1_addrB", rom_addrB_vn, 448);
        chk("t1_we_c2", ib_ram_we, 0);
        tick();
        chk("t1_we_first", ib_ram_we, 3'b111);
        chk("t1_page_first", page_addr_ram_0, 0);
        wait_done(200, n);
        chk("t1_done_cycle", 3 + n, 67);
        chk("t1_busy_done", busy, 0);
        chk("t1_writes", wr_cnt - wb, 64);
        tick();
        chk("t1_done_cnt", done_cnt - db, 1);
        repeat (3) tick();

        // Datapath not drained for 10 cycles.
        wb = wr_cnt;
        pipe_drained = 1'b0;
        do_req(4'd2);
        repeat (10) tick();
        chk("t2_addr_hold", rom_addrA_vn, 447);
        chk("t2_busy_wait", busy, 1);
        chk("t2_no_write", wr_cnt - wb, 0);
        pipe_drained = 1'b1;
        tick();
        chk("t2_addr_start", rom_addrA_vn, 256);
        wait_done(200, n);
        chk("t2_writes", wr_cnt - wb, 64);
        repeat (3) tick();

        // Abort at page 20, then a normal refresh of iteration 5.
        wb = wr_cnt; db = done_cnt;
        do_req(4'd7);
        wait_addr(7 * 128 + 20, 100);
        refresh_abort = 1'b1;
        tick();
        refresh_abort = 1'b0;
        chk("t3_we_after_abort", ib_ram_we, 0);
        chk("t3_busy_after_abort", busy, 0);
        repeat (80) tick();
        chk("t3_writes", wr_cnt - wb, 20);
        chk("t3_no_done", done_cnt - db, 0);
        wb = wr_cnt;
        do_req(4'd5);
        tick();
        chk("t3_addr5", rom_addrA_vn, 640);
        wait_done(200, n);
        chk("t3_writes5", wr_cnt - wb, 64);
        repeat (3) tick();

        // Second request while issuing is ignored.
        wb = wr_cnt; db = done_cnt;
        do_req(4'd1);
        repeat (10) tick();
        do_req(4'd9);
        wait_done(200, n);
        tick();
        repeat (80) tick();
        chk("t4_writes", wr_cnt - wb, 64);
        chk("t4_done_cnt", done_cnt - db, 1);
        chk("t4_idle", busy, 0);

        // Abort and request together while idle: request dropped.
        wb = wr_cnt;
        refresh_req = 1'b1; refresh_abort = 1'b1; refresh_iter = 4'd4;
        tick();
        refresh_req = 1'b0; refresh_abort = 1'b0;
        chk("t5_busy", busy, 0);
        repeat (70) tick();
        chk("t5_writes", wr_cnt - wb, 0);

        // Asynchronous reset mid-refresh.
        do_req(4'd4);
        wait_addr(4 * 128 + 30, 100);
        rstn = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_we", ib_ram_we, 0);
        chk("t6_addrA", rom_addrA_vn, 0);
        chk("t6_addrB_dn", rom_addrB_dn, 0);
        chk("t6_page", page_addr_ram_0, 0);
        chk("t6_data", ram_write_dataA_1, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        chk("t6_idle", busy, 0);
        wb = wr_cnt;
        do_req(4'd6);
        wait_done(200, n);
        chk("t6_writes", wr_cnt - wb, 64);
        repeat (3) tick();

`ifdef IB_REFRESH_RANGE_CHK_EN
        // Out-of-range iteration refused.
        wb = wr_cnt; eb = err_cnt;
        do_req(4'd15);
        chk("t7_err_pulse", err, 1);
        chk("t7_busy", busy, 0);
        tick();
        chk("t7_err_low", err, 0);
        repeat (70) tick();
        chk("t7_err_cnt", err_cnt - eb, 1);
        chk("t7_writes", wr_cnt - wb, 0);
`else
        eb = err_cnt;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
